sprite_layer_engine: RTL and testbench

Parametrised N-channel scrolling sprite layer for the VGA display path: it holds per-channel obstacle positions, scrolls them each frame at a run-time velocity, respawns them off the right edge, and generates per-channel sprite-ROM addresses in raster order. It composites the returned sprite bits into one layer pixel and latches player/sprite collisions. It sits between the timing generator and the final colour mux, and generalises the single-cactus / single-cloud logic to NUM_CH channels with selectable frame sequencing.

---
 rtl/dino_gfx_pkg.sv | 23 ++
 rtl/sprite_layer_engine_if.sv | 30 +++
 rtl/sprite_layer_engine_channel.sv | 105 ++++++++++
 rtl/sprite_layer_engine.sv | 128 ++++++++++++
 tb/tb_sprite_layer_engine.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dino_gfx_pkg.sv
// Shared graphics definitions for the dino VGA path: screen size, raster
// coordinate types, the 11-bit sprite position type and the frame LFSR.
package dino_gfx_pkg;

  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;

  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;

  // Sprite x positions carry an extra bit so respawn points past 1023
  // (high channel indices) stay off-screen instead of wrapping.
  typedef logic [10:0] xpos_t;

  // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sprite_layer_engine_if.sv
// Video-side bus of the sprite layer: raster timing in, sprite ROM
// address/data exchange, and the composited layer pixel out.
interface sprite_layer_engine_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 14
);
  import dino_gfx_pkg::*;

  logic                     pix_en;
  xcoord_t                  x;
  ycoord_t                  y;
  logic                     frame_end;
  logic [NUM_CH*ADDR_W-1:0] sprite_addr;
  logic [NUM_CH-1:0]        sprite_bit;
  logic                     layer_px;
  logic [2:0]               layer_ch;

  // timing generator / ROM side
  modport master (
    output pix_en, x, y, frame_end, sprite_bit,
    input  sprite_addr, layer_px, layer_ch
  );

  // sprite layer engine side
  modport slave (
    input  pix_en, x, y, frame_end, sprite_bit,
    output sprite_addr, layer_px, layer_ch
  );

endinterface

// File: rtl/sprite_layer_engine_channel.sv
// One scrolling sprite channel: position, frame select, raster offset,
// bounding-box test and the registered sprite-ROM address.
// With LFSR_FRAME_EN defined the respawn frame comes from rnd_fsel.
module sprite_channel
  import dino_gfx_pkg::*;
#(
  parameter int SPR_W     = 49,
  parameter int SPR_H     = 80,
  parameter int FRAME_CNT = 3,
  parameter int RESP_X    = 550,
  parameter int ADDR_W    = 14,
  parameter int FSEL_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  xcoord_t           x,
  input  ycoord_t           y,
  input  logic              frame_end,
  input  logic              scroll_en,
  input  logic              restart,
  input  logic [3:0]        velocity,
  input  ycoord_t           spawn_y,
`ifdef LFSR_FRAME_EN
  input  logic [FSEL_W-1:0] rnd_fsel,
`endif
  output logic [ADDR_W-1:0] sprite_addr,
  output logic              in_box_p0
);

  localparam xpos_t             RESP_XPOS = xpos_t'(RESP_X);
  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(SPR_W * SPR_H);

  xpos_t             x_pos;
  logic [FSEL_W-1:0] frame_sel;
  logic [FSEL_W-1:0] fsel_next;
  logic [ADDR_W-1:0] offset;
  logic              in_box;
  xpos_t             x_ext;
  xpos_t             vel_ext;
  logic [9:0]        y_ext;
  logic [9:0]        y_top;
  logic [9:0]        y_end;

  // Bounding-box test, widened so box edges past 1023 never wrap
  always_comb begin
    x_ext   = {1'b0, x};
    vel_ext = {7'd0, velocity};
    y_ext   = {1'b0, y};
    y_top   = {1'b0, spawn_y};
    y_end   = y_top + 10'(SPR_H);
    in_box  = (x_ext >= x_pos) && (x_ext < x_pos + xpos_t'(SPR_W)) &&
              (y_ext >= y_top) && (y_ext < y_end);
  end

  // Frame to show after the next respawn
  always_comb begin
`ifdef LFSR_FRAME_EN
    fsel_next = rnd_fsel;
`else
    fsel_next = (frame_sel == FSEL_W'(FRAME_CNT - 1)) ? '0 : frame_sel + FSEL_W'(1);
`endif
  end

  // Scroll left once per frame; respawn off the right edge when exhausted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_pos     <= RESP_XPOS;
      frame_sel <= '0;
    end else if (restart) begin
      x_pos     <= RESP_XPOS;
      frame_sel <= '0;
    end else if (frame_end && scroll_en) begin
      if (x_pos < vel_ext) begin
        x_pos     <= RESP_XPOS;
        frame_sel <= fsel_next;
      end else begin
        x_pos <= x_pos - vel_ext;
      end
    end
  end

  // Raster offset into the current frame; counts in-box pixels only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset <= '0;
    end else if (frame_end) begin
      offset <= '0;
    end else if (pix_en && in_box) begin
      offset <= offset + ADDR_W'(1);
    end
  end

  // Stage p0: ROM address and box flag, aligned to the returning sprite bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sprite_addr <= '0;
      in_box_p0   <= 1'b0;
    end else if (pix_en) begin
      sprite_addr <= ADDR_W'(frame_sel) * FRAME_PIX + offset;
      in_box_p0   <= in_box;
    end
  end

endmodule

// File: rtl/sprite_layer_engine.sv
// N-channel scrolling sprite layer: per-channel scroll/address generation,
// compositing of returned sprite bits, lowest-channel priority encode and a
// sticky player collision flag.
// Optional macro LFSR_FRAME_EN: respawn frame chosen by an 8-bit LFSR
// instead of cycling sequentially.
module sprite_layer_engine
  import dino_gfx_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int SPR_W     = 49,
  parameter int SPR_H     = 80,
  parameter int FRAME_CNT = 3,
  parameter int RESPAWN_X = 550,
  parameter int SPACING   = 160
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_layer_engine_if.slave  vid,
  input  logic                  run,
  input  logic                  restart,
  input  logic [3:0]            velocity,
  input  logic [NUM_CH*9-1:0]   spawn_y,
  input  logic                  player_px,
  output logic                  collide
);

  localparam int ADDR_W = $clog2(FRAME_CNT * SPR_W * SPR_H);
  localparam int FSEL_W = (FRAME_CNT > 1) ? $clog2(FRAME_CNT) : 1;

  logic [NUM_CH*ADDR_W-1:0] addr_all;
  logic [NUM_CH-1:0]        in_box_p0;
  logic [NUM_CH-1:0]        hit;
  logic                     hit_any;
  logic [2:0]               hit_ch;
  logic                     scroll_en;
  logic                     vld_p0;
  logic                     vld_p1;

  assign scroll_en       = run & ~collide;
  assign vid.sprite_addr = addr_all;

`ifdef LFSR_FRAME_EN
  logic [7:0]        lfsr;
  logic [FSEL_W-1:0] rnd_fsel;

  assign rnd_fsel = FSEL_W'(int'(lfsr) % FRAME_CNT);

  // Free-running frame LFSR, advanced once per frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else if (vid.frame_end) begin
      lfsr <= lfsr_step(lfsr);
    end
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sprite_channel #(
      .SPR_W     (SPR_W),
      .SPR_H     (SPR_H),
      .FRAME_CNT (FRAME_CNT),
      .RESP_X    (RESPAWN_X + i * SPACING),
      .ADDR_W    (ADDR_W),
      .FSEL_W    (FSEL_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .pix_en      (vid.pix_en),
      .x           (vid.x),
      .y           (vid.y),
      .frame_end   (vid.frame_end),
      .scroll_en   (scroll_en),
      .restart     (restart),
      .velocity    (velocity),
      .spawn_y     (spawn_y[i*9 +: 9]),
`ifdef LFSR_FRAME_EN
      .rnd_fsel    (rnd_fsel),
`endif
      .sprite_addr (addr_all[i*ADDR_W +: ADDR_W]),
      .in_box_p0   (in_box_p0[i])
    );
  end

  // Pixel strobe pipeline: p0 = address issued, p1 = ROM data returned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= vid.pix_en;
      vld_p1 <= vld_p0;
    end
  end

  // Composite channels and pick the lowest-index active one
  always_comb begin
    hit     = in_box_p0 & vid.sprite_bit;
    hit_any = |hit;
    hit_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) hit_ch = 3'(i);
    end
  end

  // Stage p2: register the layer pixel once the sprite bits are valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid.layer_px <= 1'b0;
      vid.layer_ch <= '0;
    end else if (vld_p1) begin
      vid.layer_px <= hit_any;
      vid.layer_ch <= hit_ch;
    end
  end

  // Sticky collision; restart clears it and beats a simultaneous hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collide <= 1'b0;
    end else if (restart) begin
      collide <= 1'b0;
    end else if (vld_p1 && hit_any && player_px) begin
      collide <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_layer_engine.sv
// Directed bench for sprite_layer_engine (default build, NUM_CH=4).
module tb_sprite_layer_engine;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 14;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                run = 1'b0;
  logic                restart = 1'b0;
  logic [3:0]          velocity = 4'd0;
  logic [NUM_CH*9-1:0] spawn_y = '0;
  logic                player_px = 1'b0;
  logic                collide;

  int errors = 0;
  int checks = 0;

  sprite_layer_engine_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) vid ();

  sprite_layer_engine dut (
    .clk       (clk),
    .reset     (reset),
    .vid       (vid),
    .run       (run),
    .restart   (restart),
    .velocity  (velocity),
    .spawn_y   (spawn_y),
    .player_px (player_px),
    .collide   (collide)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         px;
    int         py;
    logic [3:0] bits;
    int         exp_px;
    int         exp_ch;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic get_xpos(input int ch, output int v);
    case (ch)
      0: v = int'(dut.g_ch[0].u_ch.x_pos);
      1: v = int'(dut.g_ch[1].u_ch.x_pos);
      2: v = int'(dut.g_ch[2].u_ch.x_pos);
      default: v = int'(dut.g_ch[3].u_ch.x_pos);
    endcase
  endtask

  task automatic fe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) vid.frame_end = 1'b1;
      @(negedge clk) vid.frame_end = 1'b0;
    end
  endtask

  task automatic pulse_restart();
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
  endtask

  // One pixel: returns addr after T, layer_px after T+1, layer after T+2
  task automatic do_pix(input int px, input int py, input logic [3:0] bits,
                        input logic pl, output int l1, output int lp,
                        output int lc, output logic [NUM_CH*ADDR_W-1:0] ad);
    @(negedge clk);
    vid.x          = 10'(px);
    vid.y          = 9'(py);
    vid.sprite_bit = bits;
    player_px      = pl;
    vid.pix_en     = 1'b1;
    @(negedge clk);
    vid.pix_en = 1'b0;
    ad = vid.sprite_addr;
    @(negedge clk);
    l1 = int'(vid.layer_px);
    @(negedge clk);
    lp = int'(vid.layer_px);
    lc = int'(vid.layer_ch);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, l1, lp, lc, idx, bad_addr, bad_px, last_addr;
    logic [NUM_CH*ADDR_W-1:0] ad;

    tbl[0]  = '{752, 120, 4'b0110, 1, 1};
    tbl[1]  = '{752, 120, 4'b0100, 1, 2};
    tbl[2]  = '{752, 120, 4'b0010, 1, 1};
    tbl[3]  = '{752, 120, 4'b0000, 0, 0};
    tbl[4]  = '{745, 120, 4'b0100, 0, 0};
    tbl[5]  = '{745, 120, 4'b0010, 1, 1};
    tbl[6]  = '{790, 120, 4'b0110, 1, 2};
    tbl[7]  = '{799, 120, 4'b1111, 0, 0};
    tbl[8]  = '{752,  99, 4'b1111, 0, 0};
    tbl[9]  = '{752, 179, 4'b1111, 1, 1};
    tbl[10] = '{758, 150, 4'b0110, 1, 1};
    tbl[11] = '{759, 150, 4'b0110, 1, 2};
    tbl[12] = '{749, 150, 4'b0100, 0, 0};

    vid.pix_en     = 1'b0;
    vid.x          = '0;
    vid.y          = '0;
    vid.frame_end  = 1'b0;
    vid.sprite_bit = '0;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset state
    get_xpos(0, v); chk("rst_xpos0", v, 550);
    get_xpos(1, v); chk("rst_xpos1", v, 710);
    get_xpos(2, v); chk("rst_xpos2", v, 870);
    get_xpos(3, v); chk("rst_xpos3", v, 1030);
    chk("rst_layer_px", int'(vid.layer_px), 0);
    chk("rst_layer_ch", int'(vid.layer_ch), 0);
    chk("rst_collide", int'(collide), 0);
    chk("rst_addr0", int'(vid.sprite_addr[ADDR_W-1:0]), 0);
    chk("rst_fsel0", int'(dut.g_ch[0].u_ch.frame_sel), 0);

    // scrolling, hold when stopped, zero velocity
    run = 1'b1; velocity = 4'd5;
    fe(10);
    get_xpos(0, v); chk("scroll_x0", v, 500);
    get_xpos(1, v); chk("scroll_x1", v, 660);
    run = 1'b0;
    fe(1);
    get_xpos(0, v); chk("stopped_x0", v, 500);
    run = 1'b1; velocity = 4'd0;
    fe(1);
    get_xpos(0, v); chk("vel0_x0", v, 500);
    run = 1'b0;

    // full raster pass over channel 0's box
    spawn_y = {9'd50, 9'd50, 9'd50, 9'd50};
    do_pix(499, 50, 4'hF, 1'b0, l1, lp, lc, ad);
    chk("outside_px", lp, 0);
    idx = 0; bad_addr = 0; bad_px = 0; last_addr = -1;
    for (int yy = 50; yy < 130; yy++) begin
      for (int xx = 500; xx < 549; xx++) begin
        do_pix(xx, yy, 4'hF, 1'b0, l1, lp, lc, ad);
        if (idx == 0) begin
          chk("first_px_t1", l1, 0);
          chk("first_px_t2", lp, 1);
          chk("first_addr", int'(ad[ADDR_W-1:0]), 0);
        end
        if (int'(ad[ADDR_W-1:0]) != idx) bad_addr++;
        if (lp != 1 || lc != 0) bad_px++;
        last_addr = int'(ad[ADDR_W-1:0]);
        idx++;
      end
    end
    chk("stream_addr_errs", bad_addr, 0);
    chk("stream_px_errs", bad_px, 0);
    chk("stream_last_addr", last_addr, 3919);
    do_pix(549, 60, 4'hF, 1'b0, l1, lp, lc, ad);
    chk("right_edge_px", lp, 0);
    fe(1);
    do_pix(500, 50, 4'hF, 1'b0, l1, lp, lc, ad);
    chk("offset_clear_addr", int'(ad[ADDR_W-1:0]), 0);

    // respawn and frame sequencing
    pulse_restart();
    run = 1'b1; velocity = 4'd15;
    fe(36);
    get_xpos(0, v); chk("pre_respawn_x10", v, 10);
    velocity = 4'd7;
    fe(1);
    get_xpos(0, v); chk("pre_respawn_x3", v, 3);
    velocity = 4'd4;
    fe(1);
    get_xpos(0, v); chk("respawn_x", v, 550);
    chk("respawn_fsel1", int'(dut.g_ch[0].u_ch.frame_sel), 1);
    run = 1'b0;
    do_pix(550, 50, 4'b0001, 1'b0, l1, lp, lc, ad);
    chk("frame1_addr", int'(ad[ADDR_W-1:0]), 3920);
    chk("frame1_px", lp, 1);
    run = 1'b1; velocity = 4'd15;
    fe(37);
    get_xpos(0, v); chk("respawn2_x", v, 550);
    chk("respawn_fsel2", int'(dut.g_ch[0].u_ch.frame_sel), 2);
    fe(37);
    chk("respawn_fsel_wrap", int'(dut.g_ch[0].u_ch.frame_sel), 0);

    // bring channels 1 and 2 into overlap (x1=710, x2=750)
    pulse_restart();
    spawn_y = {9'd400, 9'd100, 9'd100, 9'd400};
    velocity = 4'd15;
    fe(480);
    run = 1'b0;
    get_xpos(1, v); chk("ovl_x1", v, 710);
    get_xpos(2, v); chk("ovl_x2", v, 750);
    for (int i = 0; i < 13; i++) begin
      do_pix(tbl[i].px, tbl[i].py, tbl[i].bits, 1'b0, l1, lp, lc, ad);
      chk($sformatf("vec%0d_px", i), lp, tbl[i].exp_px);
      chk($sformatf("vec%0d_ch", i), lc, tbl[i].exp_ch);
    end
    chk("no_player_collide", int'(collide), 0);

    // collision: player with no sprite, then with sprite
    do_pix(600, 120, 4'b0110, 1'b1, l1, lp, lc, ad);
    chk("player_only_collide", int'(collide), 0);
    do_pix(752, 120, 4'b0110, 1'b1, l1, lp, lc, ad);
    chk("hit_collide", int'(collide), 1);
    player_px = 1'b0;
    run = 1'b1;
    fe(3);
    get_xpos(1, v); chk("frozen_x1", v, 710);
    get_xpos(2, v); chk("frozen_x2", v, 750);
    chk("collide_sticky", int'(collide), 1);
    pulse_restart();
    chk("restart_collide", int'(collide), 0);
    get_xpos(1, v); chk("restart_x1", v, 710);
    get_xpos(2, v); chk("restart_x2", v, 870);
    run = 1'b0;

    // restart landing on the compositing edge beats the collision
    @(negedge clk);
    vid.x = 10'd720; vid.y = 9'd120; vid.sprite_bit = 4'b0010;
    player_px = 1'b1; vid.pix_en = 1'b1;
    @(negedge clk) vid.pix_en = 1'b0;
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    chk("coincide_px", int'(vid.layer_px), 1);
    chk("coincide_collide", int'(collide), 0);
    @(negedge clk);
    chk("coincide_collide_hold", int'(collide), 0);
    do_pix(720, 120, 4'b0010, 1'b1, l1, lp, lc, ad);
    chk("recollide", int'(collide), 1);
    player_px = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
